// File: rtl/hdlc_pkg.sv
// Shared HDLC definitions used by both the framer transmitter and the
// matching receiver.
//   FLAG         : frame delimiter, sent LSB first (0,1,1,1,1,1,1,0)
//   ONES_MAX_DEF : default run of payload 1s after which a 0 is stuffed
//   IDLE_LEVEL   : line level when nothing is being sent
//   state_t      : framer state encoding
package hdlc_pkg;

    localparam logic [7:0] FLAG         = 8'b0111_1110;
    localparam int         ONES_MAX_DEF = 5;
    localparam logic       IDLE_LEVEL   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        OPEN_FLAG,
        DATA,
        STUFF,
        CLOSE_FLAG,
        ABORT
    } state_t;

endpackage

// File: rtl/hdlc_framer_tx_if.sv
// Byte-input handshake for the HDLC framer.
//   in_valid : byte available (source -> framer)
//   in_data  : payload byte (source -> framer)
//   in_last  : final byte of the frame, qualified by in_valid
//   in_ready : framer holding register empty (framer -> source)
// Transfer happens on a rising edge with in_valid && in_ready.
interface hdlc_framer_tx_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;

    modport master (output in_valid, output in_data, output in_last, input  in_ready);
    modport slave  (input  in_valid, input  in_data, input  in_last, output in_ready);
endinterface

// File: rtl/hdlc_stuffer.sv
// Zero-bit stuffing tracker for the payload bit stream.
//   clk, reset : clock, synchronous active-high reset
//   bit_in     : payload bit currently being sent
//   en         : bit_in is a payload bit this cycle
//   clr        : restart the run count (stuff bit sent / frame start)
//   stuff_req  : this payload bit completes a run of ONES_MAX 1s
//   ones_cnt   : current run of consecutive payload 1s
module hdlc_stuffer
    import hdlc_pkg::*;
#(
    parameter int ONES_MAX = ONES_MAX_DEF,
    parameter int OW       = $clog2(ONES_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          bit_in,
    input  logic          en,
    input  logic          clr,
    output logic          stuff_req,
    output logic [OW-1:0] ones_cnt
);

    assign stuff_req = en && bit_in && (ones_cnt == OW'(ONES_MAX - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            ones_cnt <= '0;
        end else if (en) begin
            ones_cnt <= bit_in ? ones_cnt + OW'(1) : '0;
        end
    end

endmodule

// File: rtl/hdlc_framer_tx.sv
// HDLC frame transmitter: opening flag, LSB-first zero-stuffed payload,
// closing flag; abort pattern on mid-frame underrun. One line bit per clock.
//   clk, reset : clock, synchronous active-high reset
//   bus        : byte handshake (slave side), in_ready = holding register empty
//   out        : registered serial line bit, idles at 1
//   out_en     : high while a flag, data, stuff or abort bit is on out
//   underrun   : one-cycle pulse aligned with the first abort bit
module hdlc_framer_tx
    import hdlc_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ONES_MAX  = ONES_MAX_DEF,
    parameter int ABORT_LEN = 7
) (
    input  logic              clk,
    input  logic              reset,
    hdlc_framer_tx_if.slave   bus,
    output logic              out,
    output logic              out_en,
    output logic              underrun
);

    localparam int CNT_W  = 8;
    localparam int ONES_W = $clog2(ONES_MAX + 1);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                hold_full, hold_last, last_cur;
    logic [DATA_W-1:0]   hold_data, shifter;
    logic                load, boundary, pay_en, ones_clr;
    logic                line_bit, line_en, stuff_req;
    logic [ONES_W-1:0]   ones_cnt;

    assign bus.in_ready = !hold_full;

    hdlc_stuffer #(.ONES_MAX(ONES_MAX), .OW(ONES_W)) u_stuffer (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (shifter[0]),
        .en        (pay_en),
        .clr       (ones_clr),
        .stuff_req (stuff_req),
        .ones_cnt  (ones_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_last <= 1'b0;
            shifter   <= '0;
            last_cur  <= 1'b0;
            out       <= IDLE_LEVEL;
            out_en    <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            out      <= line_bit;
            out_en   <= line_en;
            underrun <= (state == ABORT) && (cnt == '0);
            // in_ready is low whenever hold is full, so a load and an accept
            // can never coincide.
            if (load) begin
                hold_full <= 1'b0;
            end else if (bus.in_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= bus.in_data;
                hold_last <= bus.in_last;
            end
            if (load) begin
                shifter  <= hold_data;
                last_cur <= hold_last;
            end else if (state == DATA) begin
                shifter  <= shifter >> 1;
            end
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        line_bit = IDLE_LEVEL;
        line_en  = 1'b0;
        load     = 1'b0;
        boundary = 1'b0;
        pay_en   = 1'b0;
        ones_clr = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    state_n = OPEN_FLAG;
                    cnt_n   = '0;
                end
            end
            OPEN_FLAG: begin
                line_bit = FLAG[cnt[2:0]];
                line_en  = 1'b1;
                if (cnt == CNT_W'(7)) begin
                    load     = 1'b1;
                    ones_clr = 1'b1;
                    state_n  = DATA;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                line_bit = shifter[0];
                line_en  = 1'b1;
                pay_en   = 1'b1;
                // cnt is held through STUFF so the boundary test happens there
                if (stuff_req) begin
                    state_n = STUFF;
                end else if (cnt == CNT_W'(DATA_W - 1)) begin
                    boundary = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STUFF: begin
                line_bit = 1'b0;
                line_en  = 1'b1;
                ones_clr = 1'b1;
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    boundary = 1'b1;
                end else begin
                    state_n = DATA;
                    cnt_n   = cnt + 1'b1;
                end
            end
            CLOSE_FLAG: begin
                line_bit = FLAG[cnt[2:0]];
                line_en  = 1'b1;
                if (cnt == CNT_W'(7)) begin
                    state_n = hold_full ? OPEN_FLAG : IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ABORT: begin
                line_bit = 1'b1;
                line_en  = 1'b1;
                if (cnt == CNT_W'(ABORT_LEN - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Byte boundary; the ones run deliberately carries into the next byte.
        if (boundary) begin
            cnt_n = '0;
            if (last_cur) begin
                state_n = CLOSE_FLAG;
            end else if (hold_full) begin
                load    = 1'b1;
                state_n = DATA;
            end else begin
                state_n = ABORT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (ones_cnt <= ONES_W'(ONES_MAX));
        end
    end

endmodule

// File: tb/tb_hdlc_framer_tx.sv
// Self-checking bench for hdlc_framer_tx: an expected line-bit queue is built
// from a reference framing model as bytes are offered, and the line monitor
// pops and compares every out_en cycle.
module tb_hdlc_framer_tx;

    typedef struct packed {
        logic b;
        logic u;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic line, line_en, und;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned pops = 0;
    int unsigned en_cycles = 0;
    int unsigned gaps = 0;
    int unsigned u_pulses = 0;
    bit          started = 1'b0;

    exp_t       exp_q[$];
    logic [7:0] pl[$];

    hdlc_framer_tx_if #(.DATA_W(8)) bus ();

    hdlc_framer_tx #(.DATA_W(8), .ONES_MAX(5), .ABORT_LEN(7)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .out      (line),
        .out_en   (line_en),
        .underrun (und)
    );

    always #5 clk = ~clk;

    // Line monitor: every out_en cycle consumes one expected bit.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (und === 1'b1) u_pulses++;
                if (line_en === 1'b1) begin
                    en_cycles++;
                    started = 1'b1;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL extra_bit: out_en=1 out=%0b underrun=%0b, required out_en=0", line, und);
                    end else begin
                        e = exp_q.pop_front();
                        pops++;
                        if (line !== e.b || und !== e.u) begin
                            n_err++;
                            $display("FAIL line_bit#%0d: out=%0b underrun=%0b, required out=%0b underrun=%0b",
                                     pops, line, und, e.b, e.u);
                        end
                    end
                end else begin
                    if (started && exp_q.size() > 0) gaps++;
                    n_cmp++;
                    if (und !== 1'b0) begin
                        n_err++;
                        $display("FAIL underrun_idle: underrun=%0b with out_en=0, required 0", und);
                    end
                end
            end
        end
    end

    // Reference framing model over the byte list in pl.
    task automatic push_frame(input bit abort);
        logic [7:0]  f;
        logic [7:0]  b;
        int unsigned ones;
        exp_t        e;
        f = 8'h7E;
        ones = 0;
        for (int i = 0; i < 8; i++) begin e.b = f[i]; e.u = 1'b0; exp_q.push_back(e); end
        foreach (pl[k]) begin
            b = pl[k];
            for (int i = 0; i < 8; i++) begin
                e.b = b[i]; e.u = 1'b0; exp_q.push_back(e);
                if (b[i]) ones++; else ones = 0;
                if (ones == 5) begin
                    e.b = 1'b0; e.u = 1'b0; exp_q.push_back(e);
                    ones = 0;
                end
            end
        end
        if (abort) begin
            for (int i = 0; i < 7; i++) begin e.b = 1'b1; e.u = (i == 0); exp_q.push_back(e); end
        end else begin
            for (int i = 0; i < 8; i++) begin e.b = f[i]; e.u = 1'b0; exp_q.push_back(e); end
        end
        pl.delete();
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int unsigned w;
        w = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (bus.in_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        if (bus.in_ready !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, w);
        end else begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL ready_after_accept: in_ready=%b, required 0", bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic start_test();
        en_cycles = 0;
        gaps = 0;
        u_pulses = 0;
        started = 1'b0;
    endtask

    // Wait for the queue to drain, then expect an idle line.
    task automatic finish_test(input string name, input int unsigned want_en);
        int unsigned w;
        w = 0;
        while (exp_q.size() != 0 && w < 400) begin @(negedge clk); #1; w++; end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d bits still expected, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (line !== 1'b1 || line_en !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle: out=%b out_en=%b, required out=1 out_en=0", name, line, line_en);
        end
        n_cmp++;
        if (en_cycles != want_en) begin
            n_err++;
            $display("FAIL %s_len: %0d out_en cycles, required %0d", name, en_cycles, want_en);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (line !== 1'b1 || line_en !== 1'b0 || bus.in_ready !== 1'b1 || und !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: out=%b out_en=%b in_ready=%b underrun=%b, required 1 0 1 0",
                     line, line_en, bus.in_ready, und);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_zero_byte();
        start_test();
        pl.push_back(8'h00); push_frame(1'b0);
        send(8'h00, 1'b1);
        finish_test("byte00", 24);
    endtask

    task automatic test_ff_byte();
        start_test();
        pl.push_back(8'hFF); push_frame(1'b0);
        send(8'hFF, 1'b1);
        finish_test("byteFF", 25);
    endtask

    task automatic test_boundary_stuff();
        start_test();
        pl.push_back(8'hF0); pl.push_back(8'h01); push_frame(1'b0);
        send(8'hF0, 1'b0);
        send(8'h01, 1'b1);
        finish_test("cross_stuff", 33);
        n_cmp++;
        if (gaps != 0) begin
            n_err++;
            $display("FAIL cross_stuff_gap: %0d gap cycles, required 0", gaps);
        end
    endtask

    task automatic test_underrun();
        start_test();
        pl.push_back(8'h55); push_frame(1'b1);
        send(8'h55, 1'b0);
        finish_test("underrun", 23);
        n_cmp++;
        if (u_pulses != 1) begin
            n_err++;
            $display("FAIL underrun_pulses: %0d pulses, required 1", u_pulses);
        end
    endtask

    task automatic test_back_to_back();
        start_test();
        pl.push_back(8'hA5); push_frame(1'b0);
        pl.push_back(8'h3C); push_frame(1'b0);
        send(8'hA5, 1'b1);
        send(8'h3C, 1'b1);
        finish_test("b2b", 48);
        n_cmp++;
        if (gaps != 0) begin
            n_err++;
            $display("FAIL b2b_gap: %0d idle cycles between frames, required 0", gaps);
        end
    endtask

    task automatic test_reset_midframe();
        int unsigned base;
        int unsigned w;
        start_test();
        pl.push_back(8'h00); push_frame(1'b0);
        base = pops;
        send(8'h00, 1'b0);
        send(8'h11, 1'b1);
        w = 0;
        // 8 flag bits + data bits 0..3 on the line
        while (pops < base + 12 && w < 300) begin @(negedge clk); #1; w++; end
        n_cmp++;
        if (pops < base + 12) begin
            n_err++;
            $display("FAIL midreset_reach: %0d bits seen, required 12", pops - base);
        end
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        n_cmp++;
        if (line !== 1'b1 || line_en !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_state: out=%b out_en=%b in_ready=%b, required 1 0 1",
                     line, line_en, bus.in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        n_cmp++;
        if (line !== 1'b1 || line_en !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_idle: out=%b out_en=%b, required out=1 out_en=0", line, line_en);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        test_reset();
        test_zero_byte();
        test_ff_byte();
        test_boundary_stuff();
        test_underrun();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
